// File: rtl/pipelined_scan_mux.sv
// Two-stage N:1 channel mux (pair select, then pair-group select) with an auto-scan
// sequencer; every output word carries the index of the channel it came from.
module pipelined_scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 4,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    output logic [WIDTH-1:0]          dout,
    output logic [SW-1:0]             dout_ch,
    output logic                      dout_valid,
    output logic                      scan_wrap
);
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PAIRS = CHANNELS / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     scan_ch_q, scan_ch_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              last_dwell_s;

    logic              issue_v_s;
    logic [SW-1:0]     issue_ch_s;
    logic              issue_wrap_s;

    logic [WIDTH-1:0]  pair_q [PAIRS];
    logic [WIDTH-1:0]  pair_d [PAIRS];
    logic [SW-1:0]     s1_ch_q;
    logic              s1_v_q;
    logic              s1_wrap_q;
    logic [WIDTH-1:0]  dout_d;

    assign last_dwell_s = (dwell_q == DW'(DWELL - 1));

    // Mode controller next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = mode ? SCAN : MANUAL;
                else    state_d = IDLE;
            end
            MANUAL: begin
                if (!en)       state_d = IDLE;
                else if (mode) state_d = SCAN;
                else           state_d = MANUAL;
            end
            SCAN: begin
                if (!en)        state_d = IDLE;
                else if (!mode) state_d = MANUAL;
                else            state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue decision for this edge: channel, valid and last-of-scan marker
    always_comb begin
        issue_v_s    = 1'b0;
        issue_ch_s   = '0;
        issue_wrap_s = 1'b0;
        case (state_q)
            MANUAL: begin
                issue_v_s  = 1'b1;
                issue_ch_s = sel;
            end
            SCAN: begin
                issue_v_s    = 1'b1;
                issue_ch_s   = scan_ch_q;
                issue_wrap_s = last_dwell_s && (scan_ch_q == SW'(CHANNELS - 1));
            end
            default: begin
                issue_v_s    = 1'b0;
                issue_ch_s   = '0;
                issue_wrap_s = 1'b0;
            end
        endcase
    end

    // Scan sequencer: a fresh entry into SCAN always restarts at channel 0
    always_comb begin
        scan_ch_d = scan_ch_q;
        dwell_d   = dwell_q;
        if (state_d == SCAN && state_q != SCAN) begin
            scan_ch_d = '0;
            dwell_d   = '0;
        end else if (state_q == SCAN) begin
            if (last_dwell_s) begin
                dwell_d   = '0;
                scan_ch_d = scan_ch_q + SW'(1);
            end else begin
                dwell_d   = dwell_q + DW'(1);
            end
        end else begin
            scan_ch_d = scan_ch_q;
            dwell_d   = dwell_q;
        end
    end

    // Level 1: each pair picks its member on the channel LSB
    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            if (issue_ch_s[0]) pair_d[p] = din[(2*p+1)*WIDTH +: WIDTH];
            else               pair_d[p] = din[(2*p)*WIDTH +: WIDTH];
        end
    end

    assign dout_d = pair_q[s1_ch_q[SW-1:1]];

    // State, sequencer and both pipeline stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_ch_q  <= '0;
            dwell_q    <= '0;
            for (int p = 0; p < PAIRS; p++) pair_q[p] <= '0;
            s1_ch_q    <= '0;
            s1_v_q     <= 1'b0;
            s1_wrap_q  <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_ch_q  <= scan_ch_d;
            dwell_q    <= dwell_d;
            pair_q     <= pair_d;
            s1_ch_q    <= issue_ch_s;
            s1_v_q     <= issue_v_s;
            s1_wrap_q  <= issue_wrap_s;
            if (s1_v_q) begin
                dout    <= dout_d;
                dout_ch <= s1_ch_q;
            end else begin
                dout    <= dout;
                dout_ch <= dout_ch;
            end
            dout_valid <= s1_v_q;
            scan_wrap  <= s1_v_q & s1_wrap_q;
        end
    end
endmodule

// File: tb/tb_pipelined_scan_mux.sv
// Bench for pipelined_scan_mux: two configurations, each with its own reference model
// and scoreboard monitor, driven by directed phases followed by random traffic.
module tb_pipelined_scan_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          ch;
        bit          wrap;
        int          cyc;
    } exp_t;

    int vectors    = 0;
    int miscompares = 0;
    bit done [2];

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int W = (g == 0) ? 8 : 16;
        localparam int C = (g == 0) ? 8 : 16;
        localparam int D = (g == 0) ? 4 : 1;
        localparam int S = $clog2(C);

        logic           rst_n = 1'b0;
        logic           en = 1'b0;
        logic           mode = 1'b0;
        logic [S-1:0]   sel = '0;
        logic [C*W-1:0] din = '0;
        logic [W-1:0]   dout;
        logic [S-1:0]   dout_ch;
        logic           dout_valid;
        logic           scan_wrap;

        pipelined_scan_mux #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
            .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
            .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .scan_wrap(scan_wrap)
        );

        exp_t q[$];
        int   st = 0;      // 0 idle, 1 manual, 2 scan
        int   n = 0;       // scan samples issued since entering scan
        int   cyc = 0;
        bit   rst_last = 1'b0;
        bit   armed = 1'b0;
        logic [W-1:0] last_d = '0;
        logic [S-1:0] last_ch = '0;

        // Reference model: what each edge issues, and when it is due on the output
        always @(posedge clk) begin
            exp_t e;
            int   ch;
            if (!rst_n) begin
                q.delete();
                st = 0;
                n = 0;
                rst_last = 1'b1;
                armed = 1'b1;
            end else begin
                rst_last = 1'b0;
                if (st != 0) begin
                    if (st == 1) begin
                        ch = int'(sel);
                        e.wrap = 1'b0;
                    end else begin
                        ch = (n / D) % C;
                        e.wrap = (ch == C - 1) && (n % D == D - 1);
                        n++;
                    end
                    e.d   = 16'(din[ch*W +: W]);
                    e.ch  = ch;
                    e.cyc = cyc;
                    q.push_back(e);
                end
                if (!en) st = 0;
                else if (mode) begin
                    if (st != 2) begin
                        st = 2;
                        n = 0;
                    end
                end else st = 1;
            end
            cyc++;
        end

        // Scoreboard monitor
        always @(negedge clk) begin
            exp_t e;
            if (armed) begin
                vectors++;
                if (rst_last) begin
                    if (dout_valid !== 1'b0 || dout !== '0 || dout_ch !== '0 || scan_wrap !== 1'b0) begin
                        miscompares++;
                        $display("FAIL cfg%0d reset: got v=%b d=%h ch=%0d wrap=%b, expected all zero",
                                 g, dout_valid, dout, dout_ch, scan_wrap);
                    end
                    last_d  = '0;
                    last_ch = '0;
                end else if (dout_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL cfg%0d spurious: got word d=%h ch=%0d, expected no valid", g, dout, dout_ch);
                    end else begin
                        e = q.pop_front();
                        if (dout !== e.d[W-1:0] || int'(dout_ch) != e.ch || scan_wrap !== e.wrap || e.cyc != cyc - 2) begin
                            miscompares++;
                            $display("FAIL cfg%0d word @%0d: got d=%h ch=%0d wrap=%b, expected d=%h ch=%0d wrap=%b issued@%0d",
                                     g, cyc, dout, dout_ch, scan_wrap, e.d[W-1:0], e.ch, e.wrap, e.cyc);
                        end
                    end
                    last_d  = dout;
                    last_ch = dout_ch;
                end else begin
                    if (dout !== last_d || dout_ch !== last_ch || scan_wrap !== 1'b0 ||
                        dout_valid !== 1'b0 || (q.size() > 0 && q[0].cyc <= cyc - 2)) begin
                        miscompares++;
                        $display("FAIL cfg%0d idle @%0d: got v=%b d=%h ch=%0d wrap=%b, expected v=0 held d=%h ch=%0d wrap=0 pending=%0d",
                                 g, cyc, dout_valid, dout, dout_ch, scan_wrap, last_d, last_ch, q.size());
                    end
                end
            end
        end

        task automatic tick(input bit r, input bit e, input bit m, input int s);
            @(negedge clk);
            rst_n = r;
            en    = e;
            mode  = m;
            sel   = S'(s);
        endtask

        initial begin
            bit m;
            for (int k = 0; k < C; k++) din[k*W +: W] = W'(16'h10 + k);
            repeat (3) tick(1'b0, 1'b1, 1'b0, 0);
            // manual sweep
            for (int k = 0; k < C; k++) tick(1'b1, 1'b1, 1'b0, k);
            repeat (2) tick(1'b1, 1'b1, 1'b0, C - 1);
            // full scan with wrap
            repeat (C*D + 6) tick(1'b1, 1'b1, 1'b1, 0);
            // mode switch mid-scan and back
            tick(1'b1, 1'b1, 1'b0, 0);
            repeat (3*D + 1) tick(1'b1, 1'b1, 1'b1, 0);
            repeat (4) tick(1'b1, 1'b1, 1'b0, C - 2);
            repeat (D + 3) tick(1'b1, 1'b1, 1'b1, 0);
            // en drop
            repeat (5) tick(1'b1, 1'b0, 1'b1, 0);
            repeat (6) tick(1'b1, 1'b1, 1'b1, 0);
            // reset mid-scan
            repeat (5*D) tick(1'b1, 1'b1, 1'b1, 0);
            tick(1'b0, 1'b1, 1'b1, 0);
            repeat (8) tick(1'b1, 1'b1, 1'b1, 0);
            // random traffic
            m = 1'b1;
            repeat (600) begin
                for (int k = 0; k < C; k++) din[k*W +: W] = W'($urandom);
                if ($urandom % 16 == 0) m = !m;
                tick(($urandom % 100) != 0, ($urandom % 8) != 0, m, int'($urandom % C));
            end
            repeat (4) tick(1'b1, 1'b0, 1'b0, 0);
            @(negedge clk);
            vectors++;
            if (q.size() != 0) begin
                miscompares++;
                $display("FAIL cfg%0d drain: got %0d undelivered words, expected 0", g, q.size());
            end
            done[g] = 1'b1;
        end
    end

    initial begin
        wait (done[0] && done[1]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
